// File: rtl/circle_buf_nbank_pkg.sv
// Shared definitions for the n-bank circular capture buffer.
// Holds the writer FSM state encoding used by circle_buf_nbank.
package circle_buf_nbank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a boundary strobe
    ST_FILL = 2'd1,  // free-running capture, wraps or hands off at bank end
    ST_POST = 2'd2,  // counting down post-stop samples
    ST_HOLD = 2'd3   // fault bank frozen, waiting for a free queue slot
  } state_t;

endpackage

// File: rtl/circle_buf_nbank_dpram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port,
// both on the same clock.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data, one clock after i_raddr
module dpram #(
  parameter int dw = 16,
  parameter int aw = 12
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [aw-1:0] i_waddr,
  input  logic [dw-1:0] i_wdata,
  input  logic [aw-1:0] i_raddr,
  output logic [dw-1:0] o_rdata
);

  logic [dw-1:0] r_mem [1<<aw];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/circle_buf_nbank.sv
// N-bank circular capture buffer. A writer fills banks in ring order and hands
// each finished bank to a reader queue; a stop trigger freezes the current bank
// after post_count+1 more samples. The writer never enters a bank the reader
// may still own: with NB-1 banks queued it wraps in place (comfort bank) or
// holds (fault bank), so the reader's bank rb is never the writer's bank wb.
//   clk, rst              : clock, synchronous active-high reset
//   d_in, stb_in          : sample data and strobe
//   boundary              : first strobe of an input block (starts a bank)
//   stop, post_count      : fault trigger and post-trigger sample count - 1
//   read_addr, i_release  : reader address within read_bank, done pulse
//                           (release is a reserved word, hence the i_ prefix)
//   d_out                 : RAM word at {read_bank, read_addr}, 1 clk latency
//   buf_ready, read_bank  : queue non-empty, bank presented to reader
//   stat_fault/wrap/end   : stored status of read_bank
//   buf_sync, buf_count   : handoff pulse and 16-bit handoff counter
//   overrun               : sticky, a comfort bank wrapped in place
module circle_buf_nbank
  import circle_buf_nbank_pkg::*;
#(
  parameter int dw = 16,
  parameter int aw = 10,
  parameter int bw = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [dw-1:0] d_in,
  input  logic          stb_in,
  input  logic          boundary,
  input  logic          stop,
  input  logic [aw-1:0] post_count,
  input  logic [aw-1:0] read_addr,
  input  logic          i_release,
  output logic [dw-1:0] d_out,
  output logic          buf_ready,
  output logic [bw-1:0] read_bank,
  output logic          stat_fault,
  output logic          stat_wrap,
  output logic [aw-1:0] stat_end,
  output logic          buf_sync,
  output logic [15:0]   buf_count,
  output logic          overrun
);

  localparam int NB = 1 << bw;

  state_t                 r_state, w_state_nxt;
  logic [bw-1:0]          r_wb, r_rb, r_cnt;
  logic [aw-1:0]          r_waddr, r_rem;
  logic [15:0]            r_buf_count;
  logic                   r_overrun, r_buf_sync;
  logic [NB-1:0]          r_st_fault, r_st_wrap;
  logic [NB-1:0][aw-1:0]  r_st_end;

  logic          w_we, w_handoff, w_freeze, w_comfort_end, w_wrap, w_load_rem;
  logic          w_full, w_last, w_rel_ok;
  logic [bw-1:0] w_wb_nxt;

  // NB-1 is all-ones in bw bits: one slot short of the whole ring
  assign w_full   = &r_cnt;
  assign w_last   = &r_waddr;
  assign w_rel_ok = i_release & (r_cnt != '0);
  assign w_wb_nxt = r_wb + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_we          = 1'b0;
    w_handoff     = 1'b0;
    w_freeze      = 1'b0;
    w_comfort_end = 1'b0;
    w_wrap        = 1'b0;
    w_load_rem    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (stb_in && boundary) begin
          w_we        = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (stb_in) begin
          w_we = 1'b1;
          if (w_last) begin
            w_comfort_end = 1'b1;
            if (!w_full) begin
              w_handoff   = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_wrap = 1'b1;
            end
          end
        end
        // a bank that just closed wins over a coincident stop
        if (stop && !w_handoff) begin
          w_load_rem  = 1'b1;
          w_state_nxt = ST_POST;
        end
      end
      ST_POST: begin
        if (stb_in) begin
          w_we = 1'b1;
          if (r_rem == '0) begin
            w_freeze = 1'b1;
            if (!w_full) begin
              w_handoff   = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt = ST_HOLD;
            end
          end else if (w_last) begin
            w_wrap = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (!w_full) begin
          w_handoff   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wb        <= '0;
      r_rb        <= '0;
      r_cnt       <= '0;
      r_waddr     <= '0;
      r_rem       <= '0;
      r_buf_count <= '0;
      r_overrun   <= 1'b0;
      r_buf_sync  <= 1'b0;
      r_st_fault  <= '0;
      r_st_wrap   <= '0;
      r_st_end    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_buf_sync <= w_handoff;
      if (w_we) r_waddr <= r_waddr + 1'b1;
      if (w_load_rem) r_rem <= post_count;
      else if (r_state == ST_POST && stb_in) r_rem <= r_rem - 1'b1;
      // status is written into the writer's bank as soon as it is known;
      // handoff only moves pointers
      if (w_comfort_end) begin
        r_st_end[r_wb]   <= '1;
        r_st_fault[r_wb] <= 1'b0;
      end
      if (w_freeze) begin
        r_st_end[r_wb]   <= r_waddr;
        r_st_fault[r_wb] <= 1'b1;
      end
      if (w_wrap) r_st_wrap[r_wb] <= 1'b1;
      if (w_comfort_end && w_full) r_overrun <= 1'b1;
      if (w_handoff) begin
        r_wb                <= w_wb_nxt;
        r_waddr             <= '0;
        r_st_wrap[w_wb_nxt] <= 1'b0;
        r_buf_count         <= r_buf_count + 16'd1;
      end
      if (w_rel_ok) r_rb <= r_rb + 1'b1;
      case ({w_handoff, w_rel_ok})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  dpram #(.dw(dw), .aw(aw + bw)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr ({r_wb, r_waddr}),
    .i_wdata (d_in),
    .i_raddr ({r_rb, read_addr}),
    .o_rdata (d_out)
  );

  assign buf_ready  = (r_cnt != '0);
  assign read_bank  = r_rb;
  assign stat_fault = r_st_fault[r_rb];
  assign stat_wrap  = r_st_wrap[r_rb];
  assign stat_end   = r_st_end[r_rb];
  assign buf_sync   = r_buf_sync;
  assign buf_count  = r_buf_count;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_circle_buf_nbank.sv
module tb_circle_buf_nbank;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] d_in;
  logic          stb_in, boundary, stop, i_release;
  logic [AW-1:0] post_count, read_addr;
  logic [DW-1:0] d_out;
  logic          buf_ready, stat_fault, stat_wrap, buf_sync, overrun;
  logic [BW-1:0] read_bank;
  logic [AW-1:0] stat_end;
  logic [15:0]   buf_count;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mdl [64];
  logic [DW-1:0] sb [$];
  logic [DW-1:0] exp_d;

  always #5 clk = ~clk;

  circle_buf_nbank #(.dw(DW), .aw(AW), .bw(BW)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .stb_in(stb_in), .boundary(boundary),
    .stop(stop), .post_count(post_count), .read_addr(read_addr),
    .i_release(i_release), .d_out(d_out), .buf_ready(buf_ready),
    .read_bank(read_bank), .stat_fault(stat_fault), .stat_wrap(stat_wrap),
    .stat_end(stat_end), .buf_sync(buf_sync), .buf_count(buf_count),
    .overrun(overrun)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  // bank < 0: strobe that must not land in RAM, so the model is untouched
  task automatic strobe(input bit bnd, input int bank, input int addr, input bit rel);
    logic [DW-1:0] v;
    v = DW'($urandom);
    d_in = v; stb_in = 1'b1; boundary = bnd; i_release = rel;
    if (bank >= 0) mdl[bank*16 + addr] = v;
    step();
    stb_in = 1'b0; boundary = 1'b0; i_release = 1'b0;
  endtask

  task automatic fill_bank(input int bank, input bit rel_last);
    for (int a = 0; a < 16; a++) strobe(a == 0, bank, a, rel_last && a == 15);
  endtask

  task automatic pulse_stop(input logic [AW-1:0] pc);
    stop = 1'b1; post_count = pc; step(); stop = 1'b0;
  endtask

  task automatic pulse_release();
    i_release = 1'b1; step(); i_release = 1'b0;
  endtask

  task automatic rd_issue(input int bank, input int addr);
    read_addr = AW'(addr);
    sb.push_back(mdl[bank*16 + addr]);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (buf_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %0b exp 0", buf_ready); end
    tests++; if (read_bank !== 2'd0) begin fails++; $display("FAIL reset_bank got %0d exp 0", read_bank); end
    tests++; if (buf_count !== 16'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", buf_count); end
    tests++; if ({overrun, buf_sync, stat_fault, stat_wrap} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b exp 0000", {overrun, buf_sync, stat_fault, stat_wrap}); end
    tests++; if (stat_end !== 4'd0) begin fails++; $display("FAIL reset_end got %0d exp 0", stat_end); end
  endtask

  task automatic test_fill();
    fill_bank(0, 1'b0);
    tests++; if (buf_sync !== 1'b1) begin fails++; $display("FAIL fill_sync got %0b exp 1", buf_sync); end
    tests++; if (buf_ready !== 1'b1 || read_bank !== 2'd0) begin fails++; $display("FAIL fill_ready got %0b/%0d exp 1/0", buf_ready, read_bank); end
    tests++; if (stat_fault !== 1'b0 || stat_wrap !== 1'b0 || stat_end !== 4'd15) begin fails++; $display("FAIL fill_stat got f%0b w%0b e%0d exp f0 w0 e15", stat_fault, stat_wrap, stat_end); end
    tests++; if (buf_count !== 16'd1) begin fails++; $display("FAIL fill_count got %0d exp 1", buf_count); end
    rd_issue(0, 5);
    tests++; if (buf_sync !== 1'b0) begin fails++; $display("FAIL fill_sync_pulse got %0b exp 0", buf_sync); end
    exp_d = sb.pop_front();
    tests++; if (d_out !== exp_d) begin fails++; $display("FAIL fill_rd5 got %h exp %h", d_out, exp_d); end
    rd_issue(0, 15);
    exp_d = sb.pop_front();
    tests++; if (d_out !== exp_d) begin fails++; $display("FAIL fill_rd15 got %h exp %h", d_out, exp_d); end
    pulse_release();
    tests++; if (buf_ready !== 1'b0 || read_bank !== 2'd1) begin fails++; $display("FAIL fill_release got %0b/%0d exp 0/1", buf_ready, read_bank); end
  endtask

  task automatic test_fault();
    for (int a = 0; a < 8; a++) strobe(a == 0, 1, a, 1'b0);
    pulse_stop(4'd3);
    for (int a = 8; a < 12; a++) begin
      tests++; if (buf_ready !== 1'b0) begin fails++; $display("FAIL fault_early got ready %0b before addr %0d exp 0", buf_ready, a); end
      strobe(1'b0, 1, a, 1'b0);
    end
    tests++; if (buf_sync !== 1'b1 || read_bank !== 2'd1) begin fails++; $display("FAIL fault_sync got %0b/%0d exp 1/1", buf_sync, read_bank); end
    tests++; if (stat_fault !== 1'b1 || stat_wrap !== 1'b0 || stat_end !== 4'd11) begin fails++; $display("FAIL fault_stat got f%0b w%0b e%0d exp f1 w0 e11", stat_fault, stat_wrap, stat_end); end
    rd_issue(1, 11);
    exp_d = sb.pop_front();
    tests++; if (d_out !== exp_d) begin fails++; $display("FAIL fault_rd11 got %h exp %h", d_out, exp_d); end
    pulse_release();
  endtask

  task automatic test_overrun();
    do_reset();
    for (int b = 0; b < 4; b++) fill_bank(b, 1'b0);
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag got %0b exp 1", overrun); end
    tests++; if (buf_count !== 16'd3 || buf_sync !== 1'b0) begin fails++; $display("FAIL ovr_count got %0d sync %0b exp 3 sync 0", buf_count, buf_sync); end
    tests++; if (read_bank !== 2'd0 || buf_ready !== 1'b1) begin fails++; $display("FAIL ovr_bank got %0d/%0b exp 0/1", read_bank, buf_ready); end
    rd_issue(0, 3);
    exp_d = sb.pop_front();
    tests++; if (d_out !== exp_d) begin fails++; $display("FAIL ovr_rd got %h exp %h", d_out, exp_d); end
  endtask

  task automatic test_hold();
    strobe(1'b0, 3, 0, 1'b0);
    strobe(1'b0, 3, 1, 1'b0);
    pulse_stop(4'd1);
    strobe(1'b0, 3, 2, 1'b0);
    strobe(1'b0, 3, 3, 1'b0);
    for (int i = 0; i < 3; i++) strobe(1'b0, -1, 0, 1'b0);
    tests++; if (buf_count !== 16'd3 || buf_sync !== 1'b0) begin fails++; $display("FAIL hold_wait got %0d sync %0b exp 3 sync 0", buf_count, buf_sync); end
    pulse_release();
    tests++; if (read_bank !== 2'd1 || buf_sync !== 1'b0) begin fails++; $display("FAIL hold_rel got %0d sync %0b exp 1 sync 0", read_bank, buf_sync); end
    step();
    tests++; if (buf_sync !== 1'b1 || buf_count !== 16'd4) begin fails++; $display("FAIL hold_handoff got sync %0b cnt %0d exp 1 4", buf_sync, buf_count); end
    pulse_release();
    pulse_release();
    tests++; if (read_bank !== 2'd3 || buf_ready !== 1'b1) begin fails++; $display("FAIL hold_bank got %0d/%0b exp 3/1", read_bank, buf_ready); end
    tests++; if (stat_fault !== 1'b1 || stat_wrap !== 1'b1 || stat_end !== 4'd3) begin fails++; $display("FAIL hold_stat got f%0b w%0b e%0d exp f1 w1 e3", stat_fault, stat_wrap, stat_end); end
    rd_issue(3, 4);
    exp_d = sb.pop_front();
    tests++; if (d_out !== exp_d) begin fails++; $display("FAIL hold_nowrite got %h exp %h", d_out, exp_d); end
    rd_issue(3, 0);
    exp_d = sb.pop_front();
    tests++; if (d_out !== exp_d) begin fails++; $display("FAIL hold_rd0 got %h exp %h", d_out, exp_d); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill_bank(0, 1'b0);
    fill_bank(1, 1'b1);
    tests++; if (buf_sync !== 1'b1 || read_bank !== 2'd1 || buf_ready !== 1'b1) begin fails++; $display("FAIL b2b_ptrs got sync %0b bank %0d rdy %0b exp 1 1 1", buf_sync, read_bank, buf_ready); end
    tests++; if (buf_count !== 16'd2 || stat_end !== 4'd15) begin fails++; $display("FAIL b2b_stat got cnt %0d end %0d exp 2 15", buf_count, stat_end); end
    rd_issue(1, 9);
    exp_d = sb.pop_front();
    tests++; if (d_out !== exp_d) begin fails++; $display("FAIL b2b_rd got %h exp %h", d_out, exp_d); end
    pulse_release();
    tests++; if (buf_ready !== 1'b0 || read_bank !== 2'd2) begin fails++; $display("FAIL b2b_cnt got %0b/%0d exp 0/2", buf_ready, read_bank); end
    fill_bank(2, 1'b0);
    rd_issue(2, 2);
    exp_d = sb.pop_front();
    tests++; if (d_out !== exp_d || buf_ready !== 1'b1) begin fails++; $display("FAIL b2b_wb got %h rdy %0b exp %h rdy 1", d_out, buf_ready, exp_d); end
  endtask

  task automatic test_rst_post();
    for (int a = 0; a < 4; a++) strobe(a == 0, 3, a, 1'b0);
    pulse_stop(4'd5);
    strobe(1'b0, 3, 4, 1'b0);
    strobe(1'b0, 3, 5, 1'b0);
    rst = 1'b1; step();
    tests++; if (buf_ready !== 1'b0 || read_bank !== 2'd0 || buf_count !== 16'd0) begin fails++; $display("FAIL rstp_ptrs got %0b %0d %0d exp 0 0 0", buf_ready, read_bank, buf_count); end
    tests++; if ({overrun, buf_sync, stat_fault, stat_wrap} !== 4'b0 || stat_end !== 4'd0) begin fails++; $display("FAIL rstp_flags got %b e%0d exp 0000 e0", {overrun, buf_sync, stat_fault, stat_wrap}, stat_end); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) strobe(1'b0, -1, 0, 1'b0);
    tests++; if (buf_ready !== 1'b0) begin fails++; $display("FAIL rstp_idle got %0b exp 0", buf_ready); end
    fill_bank(0, 1'b0);
    tests++; if (buf_count !== 16'd1 || read_bank !== 2'd0 || stat_end !== 4'd15 || stat_fault !== 1'b0) begin fails++; $display("FAIL rstp_refill got cnt %0d bank %0d end %0d f%0b exp 1 0 15 0", buf_count, read_bank, stat_end, stat_fault); end
    rd_issue(0, 6);
    exp_d = sb.pop_front();
    tests++; if (d_out !== exp_d) begin fails++; $display("FAIL rstp_rd got %h exp %h", d_out, exp_d); end
  endtask

  initial begin
    rst = 1'b1; d_in = '0; stb_in = 1'b0; boundary = 1'b0; stop = 1'b0;
    post_count = '0; read_addr = '0; i_release = 1'b0;
    test_reset();
    test_fill();
    test_fault();
    test_overrun();
    test_hold();
    test_back_to_back();
    test_rst_post();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
